// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ requesters.
// Runs entirely in the FIFO write clock domain; bursts of up to MAX_BURST beats per grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                             wr_clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               grant,
    input  logic                             fifo_full,
    output logic                             fifo_wr_en,
    output logic [DATA_WIDTH-1:0]            fifo_data_in,
    output logic                             stall
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [3:0]       LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   SHIFT_ONE = (PTR_W+1)'(1);

    logic [1:0]       state, state_nx;
    logic [NUM_REQ-1:0] grant_nx;
    logic [3:0]       beat_cnt, beat_cnt_nx;
    logic [PTR_W-1:0] last_ptr, last_ptr_nx;
    logic [PTR_W-1:0] owner_idx;
    logic [DATA_WIDTH-1:0] owner_data;
    logic             any_req;
    logic             owner_req;
    logic             beat;
    logic             burst_end;

    // Rotate so the search starts just after 'last', isolate the lowest set bit, rotate back.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                   input logic [PTR_W-1:0]   last);
        logic [PTR_W:0]     s;
        logic [NUM_REQ-1:0] rot;
        logic [NUM_REQ-1:0] first;
        s     = {1'b0, last} + SHIFT_ONE;
        rot   = NUM_REQ'({r, r} >> s);
        first = rot & (~rot + NUM_REQ'(1));
        return NUM_REQ'(({first, first} << s) >> NUM_REQ);
    endfunction

    // Owner data select and owner index encode, built from constant-index bit columns.
    logic [DATA_WIDTH-1:0][NUM_REQ-1:0] data_cols;
    logic [PTR_W-1:0][NUM_REQ-1:0]      idx_cols;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        for (genvar gb = 0; gb < DATA_WIDTH; gb++) begin : g_dbit
            assign data_cols[gb][gi] = req_data[gi*DATA_WIDTH + gb] & grant[gi];
        end
        for (genvar gp = 0; gp < PTR_W; gp++) begin : g_pbit
            if (((gi >> gp) & 1) == 1) begin : g_set
                assign idx_cols[gp][gi] = grant[gi];
            end else begin : g_clr
                assign idx_cols[gp][gi] = 1'b0;
            end
        end
    end

    for (genvar gb = 0; gb < DATA_WIDTH; gb++) begin : g_dred
        assign owner_data[gb] = |data_cols[gb];
    end

    for (genvar gp = 0; gp < PTR_W; gp++) begin : g_pred
        assign owner_idx[gp] = |idx_cols[gp];
    end

    assign any_req   = |req;
    assign owner_req = |(req & grant);
    assign beat      = (state == BURST) && owner_req && !fifo_full;

    assign fifo_wr_en   = beat;
    assign req_ack      = beat ? grant : '0;
    assign fifo_data_in = beat ? owner_data : '0;
    assign stall        = (state == HOLD);

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        beat_cnt_nx = beat_cnt;
        last_ptr_nx = last_ptr;
        burst_end   = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nx    = rr_pick(req, last_ptr);
                    beat_cnt_nx = '0;
                    state_nx    = BURST;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    burst_end = 1'b1;
                end else if (fifo_full) begin
                    state_nx = HOLD;
                end else if (beat_cnt == LAST_BEAT) begin
                    burst_end = 1'b1;
                end else begin
                    beat_cnt_nx = beat_cnt + 4'd1;
                end
            end
            HOLD: begin
                if (!owner_req) begin
                    burst_end = 1'b1;
                end else if (!fifo_full) begin
                    state_nx = BURST;
                end
            end
            default: begin
                state_nx    = IDLE;
                grant_nx    = '0;
                beat_cnt_nx = '0;
            end
        endcase

        // Hand-over: rotation restarts just past the finishing owner, no bubble.
        if (burst_end) begin
            last_ptr_nx = owner_idx;
            beat_cnt_nx = '0;
            if (any_req) begin
                grant_nx = rr_pick(req, owner_idx);
                state_nx = BURST;
            end else begin
                grant_nx = '0;
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            last_ptr <= PTR_LAST;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            beat_cnt <= beat_cnt_nx;
            last_ptr <= last_ptr_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter: requester model, expected beats queued in grant order.
module tb_fifo_wr_arbiter;

    logic        wr_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [3:0]  fifo_data_in;
    logic        stall;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (4),
        .MAX_BURST  (4)
    ) dut (
        .wr_clk       (wr_clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .grant        (grant),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .stall        (stall)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int         idx;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   rem[4];
    int   sent[4];
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   n_acks;
    int   first_ack;
    int   last_ack;

    logic [3:0] s_grant;
    logic [3:0] s_ack;
    logic       s_wr;
    logic       s_stall;
    logic [3:0] s_data;

    function automatic logic [3:0] beat_data(input int i, input int k);
        return 4'((i * 5 + k * 3 + 1) % 16);
    endfunction

    function automatic int rem_total();
        return rem[0] + rem[1] + rem[2] + rem[3];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        req      = {rem[3] > 0, rem[2] > 0, rem[1] > 0, rem[0] > 0};
        req_data = {beat_data(3, sent[3]), beat_data(2, sent[2]),
                    beat_data(1, sent[1]), beat_data(0, sent[0])};
    endtask

    task automatic add_req(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.idx  = i;
            e.data = beat_data(i, sent[i[1:0]] + rem[i[1:0]] + k);
            sb.push_back(e);
        end
        rem[i[1:0]] += n;
        drive_reqs();
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge wr_clk);
        s_grant = grant;
        s_ack   = req_ack;
        s_wr    = fifo_wr_en;
        s_stall = stall;
        s_data  = fifo_data_in;
        cyc++;
        check("ack_onehot0", 32'($onehot0(s_ack)), 32'd1);
        check("wr_en_vs_ack", 32'(s_wr), 32'(|s_ack));
        check("no_write_when_full", 32'(s_wr & fifo_full), 32'd0);
        check("grant_onehot0", 32'($onehot0(s_grant)), 32'd1);
        if (s_wr) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", 32'(s_ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 32'(s_ack), 32'd1 << e.idx);
                check("beat_data", 32'(s_data), 32'(e.data));
            end
            n_acks++;
            if (first_ack < 0) first_ack = cyc;
            last_ack = cyc;
        end
        @(posedge wr_clk);
        #1;
        if (s_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (s_ack[i[1:0]] && rem[i[1:0]] > 0) begin
                    rem[i[1:0]]--;
                    sent[i[1:0]]++;
                end
            end
        end
        drive_reqs();
    endtask

    task automatic run_done(input string tag, input int max_cycles);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || rem_total() != 0) && guard < max_cycles) begin
            cycle();
            guard++;
        end
        check({tag, "_drained"}, 32'(sb.size() + rem_total()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) rem[i[1:0]] = 0;
        sb.delete();
        drive_reqs();
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        reset_n = 1'b1;
        @(posedge wr_clk);
        #1;
        n_acks    = 0;
        first_ack = -1;
        last_ack  = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i[1:0]]  = 0;
            sent[i[1:0]] = 0;
        end
        drive_reqs();

        // Reset state
        @(posedge wr_clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_data", 32'(fifo_data_in), 32'd0);

        // Single requester, 6 beats: regrant after 4 without a bubble
        do_reset();
        add_req(0, 6);
        cycle();
        check("t1_latency_grant", 32'(s_grant), 32'd0);
        check("t1_latency_ack", 32'(s_ack), 32'd0);
        cycle();
        check("t1_grant", 32'(s_grant), 32'b0001);
        check("t1_first_ack", 32'(s_ack), 32'b0001);
        run_done("t1", 40);
        check("t1_acks", 32'(n_acks), 32'd6);
        check("t1_no_bubble", 32'(last_ack - first_ack + 1), 32'd6);

        // All four requesting: rotation 0,1,2,3,0 with 4 beats each
        do_reset();
        add_req(0, 4);
        add_req(1, 4);
        add_req(2, 4);
        add_req(3, 4);
        add_req(0, 4);
        run_done("t2", 80);
        check("t2_acks", 32'(n_acks), 32'd20);
        check("t2_no_bubble", 32'(last_ack - first_ack + 1), 32'd20);

        // req1 blocked by full after beat 2 for 5 cycles
        do_reset();
        add_req(1, 4);
        add_req(2, 1);
        guard = 0;
        while (n_acks < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        check("t3_two_beats", 32'(n_acks), 32'd2);
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("t3_full_wr_en", 32'(s_wr), 32'd0);
            if (c > 0) check("t3_stall", 32'(s_stall), 32'd1);
        end
        fifo_full = 1'b0;
        cycle();
        check("t3_bubble_wr_en", 32'(s_wr), 32'd0);
        check("t3_bubble_stall", 32'(s_stall), 32'd1);
        cycle();
        check("t3_resume_ack", 32'(s_ack), 32'b0010);
        check("t3_resume_stall", 32'(s_stall), 32'd0);
        run_done("t3", 40);
        check("t3_acks", 32'(n_acks), 32'd5);

        // req2 releases after 1 beat; rotation continues at req3, not req0
        do_reset();
        add_req(2, 1);
        cycle();
        add_req(3, 2);
        add_req(0, 2);
        cycle();
        check("t4_grant2", 32'(s_grant), 32'b0100);
        cycle();
        check("t4_release_wr_en", 32'(s_wr), 32'd0);
        cycle();
        check("t4_next_grant", 32'(s_grant), 32'b1000);
        run_done("t4", 40);
        check("t4_acks", 32'(n_acks), 32'd5);

        // Reset pulsed mid-burst
        do_reset();
        add_req(2, 4);
        guard = 0;
        while (n_acks < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        check("t5_mid_burst_grant", 32'(s_grant), 32'b0100);
        reset_n = 1'b0;
        #1;
        check("t5_async_grant", 32'(grant), 32'd0);
        check("t5_async_ack", 32'(req_ack), 32'd0);
        check("t5_async_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t5_async_stall", 32'(stall), 32'd0);
        sb.delete();
        rem[2] = 0;
        add_req(1, 1);
        add_req(2, 2);
        add_req(3, 1);
        @(negedge wr_clk);
        reset_n = 1'b1;
        @(posedge wr_clk);
        #1;
        n_acks = 0;
        cycle();
        check("t5_first_grant", 32'(s_grant), 32'b0010);
        run_done("t5", 40);
        check("t5_acks", 32'(n_acks), 32'd4);

        // Full already high when req0 arrives in IDLE
        do_reset();
        fifo_full = 1'b1;
        add_req(0, 2);
        cycle();
        cycle();
        check("t6_grant", 32'(s_grant), 32'b0001);
        check("t6_no_ack", 32'(s_ack), 32'd0);
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("t6_hold_stall", 32'(s_stall), 32'd1);
            check("t6_hold_ack", 32'(s_ack), 32'd0);
        end
        fifo_full = 1'b0;
        cycle();
        check("t6_bubble_ack", 32'(s_ack), 32'd0);
        run_done("t6", 40);
        check("t6_acks", 32'(n_acks), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
